// File: rtl/fir_mac_seq.sv
// rtl/fir_mac_seq.sv - sequential single-multiplier FIR filter
//
// Purpose: y[n] = sum_{k=0..N-1} h[k]*x[n-k], one tap per clock through a
// single multiplier/accumulator. Samples live in an N-entry circular buffer;
// coefficients are written through a simple strobe port while idle.
//
// Ports:
//   clk, rst_n               clock (rising edge), asynchronous active-low reset
//   x_data/x_valid/x_ready   input sample stream, signed W-bit, W_FRAC fraction bits
//   y_data/y_valid/y_ready   output sample stream, signed W-bit, W_FRAC fraction bits
//   coef_we/addr/data        coefficient write; honoured only while idle and addr < N
//   busy                     high whenever the FSM is not idle
//   overflow                 qualifies y_data: result did not fit in W bits
//
// Configuration: define FIR_MAC_SEQ_SATURATE_EN to clamp out-of-range results
// to the W-bit signed limits; otherwise the result wraps. overflow is flagged
// in both builds.

module fir_mac_seq #(
    parameter int W      = 32,
    parameter int W_FRAC = 16,
    parameter int N      = 41
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [W-1:0]           x_data,
    input  logic                   x_valid,
    output logic                   x_ready,
    output logic [W-1:0]           y_data,
    output logic                   y_valid,
    input  logic                   y_ready,
    input  logic                   coef_we,
    input  logic [$clog2(N)-1:0]   coef_addr,
    input  logic [W-1:0]           coef_data,
    output logic                   busy,
    output logic                   overflow
);

    localparam int AW    = $clog2(N);
    localparam int ACC_W = 2 * W + AW + 1;
    // Bits above the output slice, including its sign bit; all must agree
    // for the shifted accumulator to fit in W bits.
    localparam int HI_W  = ACC_W - (W - 1 + W_FRAC);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MAC  = 2'd1,
        S_OUT  = 2'd2
    } state_t;

    state_t                   r_state;
    logic signed [W-1:0]      r_buf  [N];
    logic signed [W-1:0]      r_coef [N];
    logic [AW-1:0]            r_wr_ptr;
    logic [AW-1:0]            r_k;
    logic signed [ACC_W-1:0]  r_acc;

    logic [AW-1:0]            w_rd_idx;
    logic signed [W-1:0]      w_sample;
    logic signed [W-1:0]      w_coef;
    logic signed [2*W-1:0]    w_prod;
    logic signed [ACC_W-1:0]  w_acc_sum;
    logic [HI_W-1:0]          w_hi;
    logic                     w_ovf;
    logic [W-1:0]             w_y;
    logic                     w_coef_ok;

    assign x_ready = (r_state == S_IDLE);
    assign busy    = (r_state != S_IDLE);

    // r_wr_ptr still points at the newest sample during MAC; tap k reads
    // the sample k steps older, wrapping around the circular buffer.
    always_comb begin
        w_rd_idx = '0;
        if (r_k > r_wr_ptr) begin
            w_rd_idx = AW'(int'(r_wr_ptr) - int'(r_k) + N);
        end else begin
            w_rd_idx = r_wr_ptr - r_k;
        end
    end

    assign w_sample  = r_buf[w_rd_idx];
    assign w_coef    = r_coef[r_k];
    assign w_prod    = w_coef * w_sample;
    assign w_acc_sum = r_acc + {{(ACC_W - 2 * W){w_prod[2*W-1]}}, w_prod};

    assign w_hi  = w_acc_sum[ACC_W-1 -: HI_W];
    assign w_ovf = !((&w_hi) || !(|w_hi));

`ifdef FIR_MAC_SEQ_SATURATE_EN
    always_comb begin
        w_y = w_acc_sum[W-1+W_FRAC:W_FRAC];
        if (w_ovf) begin
            w_y = w_acc_sum[ACC_W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
        end
    end
`else
    // Arithmetic shift then truncation: rounds toward minus infinity, wraps.
    assign w_y = w_acc_sum[W-1+W_FRAC:W_FRAC];
`endif

    assign w_coef_ok = coef_we && ({1'b0, coef_addr} < (AW + 1)'(N));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            y_valid  <= 1'b0;
            y_data   <= '0;
            overflow <= 1'b0;
            r_wr_ptr <= '0;
            r_k      <= '0;
            r_acc    <= '0;
            for (int i = 0; i < N; i++) begin
                r_buf[i]  <= '0;
                r_coef[i] <= '0;
            end
        end else begin
            // A write in the handshake cycle lands before MAC reads h.
            if (r_state == S_IDLE && w_coef_ok) begin
                r_coef[coef_addr] <= coef_data;
            end

            case (r_state)
                S_IDLE: begin
                    if (x_valid) begin
                        r_buf[r_wr_ptr] <= x_data;
                        r_acc           <= '0;
                        r_k             <= '0;
                        r_state         <= S_MAC;
                    end
                end
                S_MAC: begin
                    r_acc <= w_acc_sum;
                    if (r_k == AW'(N - 1)) begin
                        y_data   <= w_y;
                        overflow <= w_ovf;
                        y_valid  <= 1'b1;
                        r_wr_ptr <= (r_wr_ptr == AW'(N - 1)) ? '0 : r_wr_ptr + 1'b1;
                        r_state  <= S_OUT;
                    end else begin
                        r_k <= r_k + 1'b1;
                    end
                end
                S_OUT: begin
                    if (y_ready) begin
                        y_valid <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fir_mac_seq.sv
// tb/tb_fir_mac_seq.sv - self-checking bench for fir_mac_seq (N=4)

module tb_fir_mac_seq;

    localparam int N = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] x_data;
    logic        x_valid;
    logic        x_ready;
    logic [31:0] y_data;
    logic        y_valid;
    logic        y_ready;
    logic        coef_we;
    logic [1:0]  coef_addr;
    logic [31:0] coef_data;
    logic        busy;
    logic        overflow;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic signed [31:0] m_h [N];
    logic signed [31:0] m_x [N];

    fir_mac_seq #(.W(32), .W_FRAC(16), .N(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .x_data    (x_data),
        .x_valid   (x_valid),
        .x_ready   (x_ready),
        .y_data    (y_data),
        .y_valid   (y_valid),
        .y_ready   (y_ready),
        .coef_we   (coef_we),
        .coef_addr (coef_addr),
        .coef_data (coef_data),
        .busy      (busy),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference: direct-form convolution over the last N accepted samples.
    function automatic void model_reset();
        for (int i = 0; i < N; i++) begin
            m_h[i] = '0;
            m_x[i] = '0;
        end
    endfunction

    function automatic void model_push(input logic [31:0] xv, output logic [31:0] ye, output logic oe);
        logic signed [127:0] acc;
        logic signed [127:0] sh;
        for (int i = N - 1; i > 0; i--) m_x[i] = m_x[i-1];
        m_x[0] = xv;
        acc = '0;
        for (int k = 0; k < N; k++) acc += 128'(m_h[k]) * 128'(m_x[k]);
        sh = acc >>> 16;
        oe = (sh > 128'sh7FFFFFFF) || (sh < -128'sh80000000);
        ye = sh[31:0];
`ifdef FIR_MAC_SEQ_SATURATE_EN
        if (oe) ye = (sh < 0) ? 32'h80000000 : 32'h7FFFFFFF;
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; x_valid = 1'b0; x_data = '0; y_ready = 1'b1;
        coef_we = 1'b0; coef_addr = '0; coef_data = '0;
        tick(); tick();
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic load_h(input logic [31:0] h0, input logic [31:0] h1,
                          input logic [31:0] h2, input logic [31:0] h3);
        logic [31:0] hv [N];
        hv[0] = h0; hv[1] = h1; hv[2] = h2; hv[3] = h3;
        for (int i = 0; i < N; i++) begin
            coef_we = 1'b1; coef_addr = 2'(i); coef_data = hv[i];
            tick();
            m_h[i] = hv[i];
        end
        coef_we = 1'b0;
    endtask

    // Offers one sample; lat counts cycles from the handshake cycle to the
    // first cycle with y_valid. Leaves y_valid pending (not consumed).
    task automatic send(input logic [31:0] xv, input bit wr_same, input logic [1:0] wa,
                        input logic [31:0] wd, input bit wr_busy, output int lat, output int hs_cyc);
        int wait_cnt;
        wait_cnt = 0;
        x_data = xv; x_valid = 1'b1;
        while (!x_ready && wait_cnt < 50) begin
            tick();
            wait_cnt++;
        end
        hs_cyc = cyc;
        if (wr_same) begin
            coef_we = 1'b1; coef_addr = wa; coef_data = wd;
        end
        lat = 0;
        do begin
            tick();
            lat++;
            x_valid = 1'b0; coef_we = 1'b0;
            if (wr_busy && lat == 1) begin
                coef_we = 1'b1; coef_addr = 2'd0; coef_data = 32'h7FFFFFFF;
            end
        end while (!y_valid && lat < 50);
        coef_we = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (x_ready !== 1'b1)  begin errors++; $display("FAIL reset_x_ready got %b want 1", x_ready); end
        checks++; if (y_valid !== 1'b0)  begin errors++; $display("FAIL reset_y_valid got %b want 0", y_valid); end
        checks++; if (y_data !== 32'h0)  begin errors++; $display("FAIL reset_y_data got %h want 0", y_data); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got %b want 0", overflow); end
        checks++; if (busy !== 1'b0)     begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    endtask

    // Impulse through h = {1.0, 0.5, 0.25, 0.125}; optionally attempts a
    // coefficient write while busy on the first sample.
    task automatic test_impulse(input bit wr_busy);
        logic [31:0] exp_y [5];
        logic [31:0] ye;
        logic        oe;
        int          lat, hs;
        exp_y[0] = 32'h00010000; exp_y[1] = 32'h00008000; exp_y[2] = 32'h00004000;
        exp_y[3] = 32'h00002000; exp_y[4] = 32'h00000000;
        for (int i = 0; i < 5; i++) begin
            send((i == 0) ? 32'h00010000 : 32'h0, 1'b0, 2'd0, 32'h0, wr_busy && (i == 0), lat, hs);
            model_push((i == 0) ? 32'h00010000 : 32'h0, ye, oe);
            checks++; if (y_data !== exp_y[i]) begin errors++; $display("FAIL impulse_y[%0d] got %h want %h", i, y_data, exp_y[i]); end
            checks++; if (y_data !== ye)       begin errors++; $display("FAIL impulse_model[%0d] got %h want %h", i, y_data, ye); end
            checks++; if (overflow !== 1'b0)   begin errors++; $display("FAIL impulse_ovf[%0d] got %b want 0", i, overflow); end
            checks++; if (lat !== N + 1)       begin errors++; $display("FAIL impulse_lat[%0d] got %0d want %0d", i, lat, N + 1); end
            tick();
            checks++; if (y_valid !== 1'b0)    begin errors++; $display("FAIL impulse_drop[%0d] got %b want 0", i, y_valid); end
        end
    endtask

    task automatic test_dc();
        int lat, hs, prev_hs;
        prev_hs = 0;
        do_reset();
        load_h(32'h00010000, 32'h00008000, 32'h00004000, 32'h00002000);
        for (int i = 0; i < 6; i++) begin
            logic [31:0] ye;
            logic        oe;
            send(32'h00010000, 1'b0, 2'd0, 32'h0, 1'b0, lat, hs);
            model_push(32'h00010000, ye, oe);
            checks++; if (lat !== N + 1) begin errors++; $display("FAIL dc_lat[%0d] got %0d want %0d", i, lat, N + 1); end
            checks++; if (y_data !== ye) begin errors++; $display("FAIL dc_model[%0d] got %h want %h", i, y_data, ye); end
            if (i >= 3) begin
                checks++; if (y_data !== 32'h0001E000) begin errors++; $display("FAIL dc_settle[%0d] got %h want 0001e000", i, y_data); end
            end
            if (i >= 1) begin
                checks++; if (hs - prev_hs !== N + 2) begin errors++; $display("FAIL dc_period[%0d] got %0d want %0d", i, hs - prev_hs, N + 2); end
            end
            prev_hs = hs;
            tick();
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] ye;
        logic        oe;
        int          lat, hs;
        do_reset();
        load_h(32'h00010000, 32'h00008000, 32'h00004000, 32'h00002000);
        y_ready = 1'b0;
        send(32'h00010000, 1'b0, 2'd0, 32'h0, 1'b0, lat, hs);
        model_push(32'h00010000, ye, oe);
        x_valid = 1'b1; x_data = 32'h12345678;
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++; if (y_valid !== 1'b1) begin errors++; $display("FAIL bp_valid[%0d] got %b want 1", i, y_valid); end
            checks++; if (y_data !== ye)    begin errors++; $display("FAIL bp_data[%0d] got %h want %h", i, y_data, ye); end
            checks++; if (x_ready !== 1'b0) begin errors++; $display("FAIL bp_x_ready[%0d] got %b want 0", i, x_ready); end
        end
        y_ready = 1'b1;
        tick();
        x_valid = 1'b0;
        checks++; if (y_valid !== 1'b0) begin errors++; $display("FAIL bp_release got %b want 0", y_valid); end
        send(32'h0, 1'b0, 2'd0, 32'h0, 1'b0, lat, hs);
        model_push(32'h0, ye, oe);
        checks++; if (y_data !== 32'h00008000) begin errors++; $display("FAIL bp_no_accept got %h want 00008000", y_data); end
        tick();
    endtask

    task automatic test_coef_busy();
        do_reset();
        load_h(32'h00010000, 32'h00008000, 32'h00004000, 32'h00002000);
        test_impulse(1'b1);
    endtask

    task automatic test_overflow();
        logic [31:0] ye;
        logic        oe;
        logic [31:0] first_exp;
        int          lat, hs;
`ifdef FIR_MAC_SEQ_SATURATE_EN
        first_exp = 32'h7FFFFFFF;
`else
        first_exp = 32'hFFFF0000;
`endif
        do_reset();
        load_h(32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF);
        for (int i = 0; i < 4; i++) begin
            send(32'h7FFFFFFF, 1'b0, 2'd0, 32'h0, 1'b0, lat, hs);
            model_push(32'h7FFFFFFF, ye, oe);
            checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag[%0d] got %b want 1", i, overflow); end
            checks++; if (y_data !== ye)     begin errors++; $display("FAIL ovf_model[%0d] got %h want %h", i, y_data, ye); end
            if (i == 0) begin
                checks++; if (y_data !== first_exp) begin errors++; $display("FAIL ovf_first got %h want %h", y_data, first_exp); end
            end
            tick();
        end
    endtask

    task automatic test_reset_mid();
        bit seen;
        do_reset();
        load_h(32'h00010000, 32'h00008000, 32'h00004000, 32'h00002000);
        x_data = 32'h00010000; x_valid = 1'b1;
        tick();
        x_valid = 1'b0;
        tick(); tick();
        rst_n = 1'b0;
        #1;
        checks++; if (busy !== 1'b0)    begin errors++; $display("FAIL mid_busy got %b want 0", busy); end
        checks++; if (y_valid !== 1'b0) begin errors++; $display("FAIL mid_y_valid got %b want 0", y_valid); end
        tick(); tick();
        rst_n = 1'b1;
        model_reset();
        checks++; if (x_ready !== 1'b1) begin errors++; $display("FAIL mid_x_ready got %b want 1", x_ready); end
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (y_valid) seen = 1'b1;
        end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL mid_no_pulse got %b want 0", seen); end
        load_h(32'h00010000, 32'h00008000, 32'h00004000, 32'h00002000);
        test_impulse(1'b0);
    endtask

    task automatic test_random();
        logic [31:0] ye;
        logic        oe;
        logic [31:0] v, wd;
        logic [1:0]  wa;
        bit          same;
        int          lat, hs, hold;
        do_reset();
        for (int i = 0; i < N; i++) begin
            v = $urandom;
            coef_we = 1'b1; coef_addr = 2'(i); coef_data = {{8{v[31]}}, v[31:8]};
            tick();
            m_h[i] = coef_data;
        end
        coef_we = 1'b0;
        for (int s = 0; s < 40; s++) begin
            v    = $urandom;
            v    = {{8{v[31]}}, v[31:8]};
            same = ($urandom_range(0, 3) == 0);
            wa   = 2'($urandom_range(0, N - 1));
            wd   = $urandom;
            wd   = {{10{wd[31]}}, wd[31:10]};
            hold = $urandom_range(0, 3);
            y_ready = 1'b0;
            send(v, same, wa, wd, 1'b0, lat, hs);
            if (same) m_h[wa] = wd;
            model_push(v, ye, oe);
            checks++; if (lat !== N + 1) begin errors++; $display("FAIL rnd_lat[%0d] got %0d want %0d", s, lat, N + 1); end
            repeat (hold) tick();
            checks++; if (y_data !== ye)   begin errors++; $display("FAIL rnd_y[%0d] got %h want %h", s, y_data, ye); end
            checks++; if (overflow !== oe) begin errors++; $display("FAIL rnd_ovf[%0d] got %b want %b", s, overflow, oe); end
            y_ready = 1'b1;
            tick();
        end
    endtask

    initial begin
        test_reset();
        do_reset();
        load_h(32'h00010000, 32'h00008000, 32'h00004000, 32'h00002000);
        test_impulse(1'b0);
        test_dc();
        test_backpressure();
        test_coef_busy();
        test_overflow();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
